// File: rtl/cnn_accel_ahb_regs.sv
`default_nettype none
// ============================================================================
// Module   : cnn_accel_ahb_regs
// Brief    : AHB-Lite word register file holding CNN accelerator configuration,
//            start command pulses and sticky done/busy status.
// Revision : 1.0
// ============================================================================
module cnn_accel_ahb_regs #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int N_REGS = 9
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [W_ADDR-1:0] HADDR,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [W_DATA-1:0] HWDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [W_DATA-1:0] HRDATA,
  output logic [31:0]       img_base,
  output logic [24:0]       frame_size,
  output logic [11:0]       width,
  output logic [11:0]       height,
  output logic [11:0]       start_up_delay,
  output logic [11:0]       hsync_delay,
  output logic [19:0]       base_weight,
  output logic [11:0]       base_param,
  output logic [15:0]       layer_cfg,
  output logic              dma_start,
  output logic              layer_start,
  input  logic              dma_done_i,
  input  logic              layer_done_i
);

  localparam logic [3:0] c_REG_IMG_BASE     = 4'h0;
  localparam logic [3:0] c_REG_IMG_LOAD     = 4'h1;
  localparam logic [3:0] c_REG_FRAME_SIZE   = 4'h2;
  localparam logic [3:0] c_REG_WIDTH_HEIGHT = 4'h3;
  localparam logic [3:0] c_REG_DELAY        = 4'h4;
  localparam logic [3:0] c_REG_BASE_ADDR    = 4'h5;
  localparam logic [3:0] c_REG_LAYER_CFG    = 4'h6;
  localparam logic [3:0] c_REG_LAYER_START  = 4'h7;
  localparam logic [3:0] c_REG_LAYER_DONE   = 4'h8;
  localparam logic [4:0] c_N_REGS           = 5'(N_REGS);

  // Address phase decode
  logic        w_addr_acc;
  logic [3:0]  w_addr_idx;
  logic        w_addr_map;
  logic        w_rd_acc;
  logic [31:0] w_wdata;
  logic        w_unused;

  // Data phase pipeline
  logic        r_dp_wr;
  logic [3:0]  r_dp_idx;
  logic        w_wr_en;

  // Stored configuration and command bits
  logic [31:0] r_img_base,     w_img_base_nxt;
  logic [24:0] r_frame_size,   w_frame_size_nxt;
  logic [11:0] r_width,        w_width_nxt;
  logic [11:0] r_height,       w_height_nxt;
  logic [11:0] r_start_up,     w_start_up_nxt;
  logic [11:0] r_hsync,        w_hsync_nxt;
  logic [19:0] r_base_weight,  w_base_weight_nxt;
  logic [11:0] r_base_param,   w_base_param_nxt;
  logic [15:0] r_layer_cfg,    w_layer_cfg_nxt;
  logic        r_dma_cmd,      w_dma_cmd_nxt;
  logic        r_layer_cmd,    w_layer_cmd_nxt;

  // Pulses and status
  logic        r_dma_start;
  logic        r_layer_start;
  logic        r_dma_done;
  logic        r_layer_done;
  logic        r_busy;

  logic [31:0] w_rd_data;
  logic [31:0] r_hrdata;

  assign w_addr_acc = HSEL & HREADY & HTRANS[1];
  assign w_addr_idx = HADDR[5:2];
  assign w_addr_map = (HADDR[W_ADDR-1:6] == '0) && ({1'b0, w_addr_idx} < c_N_REGS);
  assign w_rd_acc   = w_addr_acc & ~HWRITE;
  assign w_wdata    = 32'(HWDATA);
  assign w_unused   = ^{HSIZE, HADDR[1:0], HTRANS[0]};

  // A stalled bus (HREADY low) freezes the pending data phase in place.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_wr  <= 1'b0;
      r_dp_idx <= '0;
    end else if (HREADY) begin
      r_dp_wr  <= w_addr_acc & HWRITE & w_addr_map;
      r_dp_idx <= w_addr_idx;
    end
  end

  assign w_wr_en = r_dp_wr & HREADY;

  // Configuration 0x08-0x18 is frozen while a layer runs.
  always_comb begin
    w_img_base_nxt    = r_img_base;
    w_frame_size_nxt  = r_frame_size;
    w_width_nxt       = r_width;
    w_height_nxt      = r_height;
    w_start_up_nxt    = r_start_up;
    w_hsync_nxt       = r_hsync;
    w_base_weight_nxt = r_base_weight;
    w_base_param_nxt  = r_base_param;
    w_layer_cfg_nxt   = r_layer_cfg;
    w_dma_cmd_nxt     = r_dma_cmd;
    w_layer_cmd_nxt   = r_layer_cmd;
    if (w_wr_en) begin
      case (r_dp_idx)
        c_REG_IMG_BASE:     w_img_base_nxt = w_wdata;
        c_REG_IMG_LOAD:     w_dma_cmd_nxt  = w_wdata[0];
        c_REG_FRAME_SIZE: begin
          if (!r_busy) w_frame_size_nxt = w_wdata[24:0];
        end
        c_REG_WIDTH_HEIGHT: begin
          if (!r_busy) begin
            w_width_nxt  = w_wdata[11:0];
            w_height_nxt = w_wdata[27:16];
          end
        end
        c_REG_DELAY: begin
          if (!r_busy) begin
            w_start_up_nxt = w_wdata[11:0];
            w_hsync_nxt    = w_wdata[23:12];
          end
        end
        c_REG_BASE_ADDR: begin
          if (!r_busy) begin
            w_base_weight_nxt = w_wdata[19:0];
            w_base_param_nxt  = w_wdata[31:20];
          end
        end
        c_REG_LAYER_CFG: begin
          if (!r_busy) w_layer_cfg_nxt = w_wdata[15:0];
        end
        c_REG_LAYER_START:  w_layer_cmd_nxt = w_wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_img_base    <= '0;
      r_frame_size  <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_start_up    <= '0;
      r_hsync       <= '0;
      r_base_weight <= '0;
      r_base_param  <= '0;
      r_layer_cfg   <= '0;
      r_dma_cmd     <= 1'b0;
      r_layer_cmd   <= 1'b0;
      r_dma_start   <= 1'b0;
      r_layer_start <= 1'b0;
    end else begin
      r_img_base    <= w_img_base_nxt;
      r_frame_size  <= w_frame_size_nxt;
      r_width       <= w_width_nxt;
      r_height      <= w_height_nxt;
      r_start_up    <= w_start_up_nxt;
      r_hsync       <= w_hsync_nxt;
      r_base_weight <= w_base_weight_nxt;
      r_base_param  <= w_base_param_nxt;
      r_layer_cfg   <= w_layer_cfg_nxt;
      r_dma_cmd     <= w_dma_cmd_nxt;
      r_layer_cmd   <= w_layer_cmd_nxt;
      r_dma_start   <= w_dma_cmd_nxt & ~r_dma_cmd;
      r_layer_start <= w_layer_cmd_nxt & ~r_layer_cmd;
    end
  end

  // An incoming done pulse takes priority over a same-cycle start pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_dma_done   <= 1'b0;
    end else begin
      if (layer_done_i) begin
        r_busy       <= 1'b0;
        r_layer_done <= 1'b1;
      end else if (r_layer_start) begin
        r_busy       <= 1'b1;
        r_layer_done <= 1'b0;
      end
      if (dma_done_i) begin
        r_dma_done <= 1'b1;
      end else if (r_dma_start) begin
        r_dma_done <= 1'b0;
      end
    end
  end

  // Reading the next-state values lets a read see a write committing this edge.
  always_comb begin
    w_rd_data = '0;
    if (w_addr_map) begin
      case (w_addr_idx)
        c_REG_IMG_BASE:     w_rd_data = w_img_base_nxt;
        c_REG_IMG_LOAD:     w_rd_data = {31'd0, r_dma_done};
        c_REG_FRAME_SIZE:   w_rd_data = {7'd0, w_frame_size_nxt};
        c_REG_WIDTH_HEIGHT: w_rd_data = {4'd0, w_height_nxt, 4'd0, w_width_nxt};
        c_REG_DELAY:        w_rd_data = {8'd0, w_hsync_nxt, w_start_up_nxt};
        c_REG_BASE_ADDR:    w_rd_data = {w_base_param_nxt, w_base_weight_nxt};
        c_REG_LAYER_CFG:    w_rd_data = {16'd0, w_layer_cfg_nxt};
        c_REG_LAYER_DONE:   w_rd_data = {30'd0, r_busy, r_layer_done};
        default:            w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (HREADY) begin
      r_hrdata <= w_rd_acc ? w_rd_data : '0;
    end
  end

  assign HREADYOUT      = 1'b1;
  assign HRESP          = 2'b00;
  assign HRDATA         = W_DATA'(r_hrdata);
  assign img_base       = r_img_base;
  assign frame_size     = r_frame_size;
  assign width          = r_width;
  assign height         = r_height;
  assign start_up_delay = r_start_up;
  assign hsync_delay    = r_hsync;
  assign base_weight    = r_base_weight;
  assign base_param     = r_base_param;
  assign layer_cfg      = r_layer_cfg;
  assign dma_start      = r_dma_start;
  assign layer_start    = r_layer_start;

endmodule
`default_nettype wire

// File: tb/tb_cnn_accel_ahb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_accel_ahb_regs
// Brief    : Scoreboard bench for cnn_accel_ahb_regs with a register-map model.
// Revision : 1.0
// ============================================================================
module tb_cnn_accel_ahb_regs;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [31:0] img_base;
  logic [24:0] frame_size;
  logic [11:0] width, height, start_up_delay, hsync_delay, base_param;
  logic [19:0] base_weight;
  logic [15:0] layer_cfg;
  logic        dma_start, layer_start;
  logic        dma_done_i = 1'b0, layer_done_i = 1'b0;

  always #5 HCLK = ~HCLK;

  cnn_accel_ahb_regs dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HADDR(HADDR), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .img_base(img_base), .frame_size(frame_size), .width(width), .height(height),
    .start_up_delay(start_up_delay), .hsync_delay(hsync_delay),
    .base_weight(base_weight), .base_param(base_param), .layer_cfg(layer_cfg),
    .dma_start(dma_start), .layer_start(layer_start),
    .dma_done_i(dma_done_i), .layer_done_i(layer_done_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_lstart = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: register map as words ----------------
  logic [31:0] m_reg [0:8];
  logic        m_dma_cmd = 0, m_layer_cmd = 0, m_dma_pulse = 0, m_layer_pulse = 0;
  logic        m_dma_done = 0, m_layer_done = 0, m_busy = 0;
  logic        m_pw = 0;
  logic [31:0] m_pw_addr = '0;
  logic        m_nd, m_nl;
  logic [3:0]  m_idx;
  logic [31:0] expq[$];

  function automatic logic is_mapped(input logic [31:0] a);
    return (a[31:6] == 26'd0) && (a[5:2] < 4'd9);
  endfunction

  function automatic logic [31:0] cfg_mask(input logic [3:0] i);
    case (i)
      4'd0: return 32'hFFFF_FFFF;
      4'd2: return 32'h01FF_FFFF;
      4'd3: return 32'h0FFF_0FFF;
      4'd4: return 32'h00FF_FFFF;
      4'd5: return 32'hFFFF_FFFF;
      4'd6: return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] view(input logic [3:0] i);
    case (i)
      4'd1: return {31'd0, m_dma_done};
      4'd8: return {30'd0, m_busy, m_layer_done};
      4'd7: return 32'd0;
      default: return m_reg[i];
    endcase
  endfunction

  initial for (int i = 0; i < 9; i++) m_reg[i] = '0;

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      for (int i = 0; i < 9; i++) m_reg[i] = '0;
      m_dma_cmd = 0; m_layer_cmd = 0; m_dma_pulse = 0; m_layer_pulse = 0;
      m_dma_done = 0; m_layer_done = 0; m_busy = 0; m_pw = 0;
      expq.delete();
    end else begin
      m_nd = m_dma_cmd;
      m_nl = m_layer_cmd;
      if (HREADY && m_pw && is_mapped(m_pw_addr)) begin
        m_idx = m_pw_addr[5:2];
        if (m_idx == 4'd1) m_nd = HWDATA[0];
        else if (m_idx == 4'd7) m_nl = HWDATA[0];
        else if (m_idx == 4'd0) m_reg[0] = HWDATA;
        else if (m_idx >= 4'd2 && m_idx <= 4'd6 && !m_busy) m_reg[m_idx] = HWDATA & cfg_mask(m_idx);
      end
      if (HREADY && HSEL && HTRANS[1] && !HWRITE)
        expq.push_back(is_mapped(HADDR) ? view(HADDR[5:2]) : 32'd0);
      if (layer_done_i) begin m_busy = 0; m_layer_done = 1; end
      else if (m_layer_pulse) begin m_busy = 1; m_layer_done = 0; end
      if (dma_done_i) m_dma_done = 1;
      else if (m_dma_pulse) m_dma_done = 0;
      m_layer_pulse = m_nl & ~m_layer_cmd;
      m_dma_pulse   = m_nd & ~m_dma_cmd;
      m_layer_cmd   = m_nl;
      m_dma_cmd     = m_nd;
      if (HREADY) begin
        m_pw      = HSEL && HTRANS[1] && HWRITE;
        m_pw_addr = HADDR;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        new_rd = 0;
  logic [31:0] exp_rd;

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) new_rd = 0;
    else new_rd = HREADY && HSEL && HTRANS[1] && !HWRITE;
  end

  initial forever begin
    @(negedge HCLK);
    if (HRESETn) begin
      check("bus_resp", {HREADYOUT, HRESP}, 3'b100);
      check("pulses", {dma_start, layer_start}, {m_dma_pulse, m_layer_pulse});
      check("cfg_out",
            {img_base, frame_size, width, height, start_up_delay, hsync_delay,
             base_weight, base_param, layer_cfg},
            {m_reg[0], m_reg[2][24:0], m_reg[3][11:0], m_reg[3][27:16], m_reg[4][11:0],
             m_reg[4][23:12], m_reg[5][19:0], m_reg[5][31:20], m_reg[6][15:0]});
      if (layer_start) n_lstart++;
      if (new_rd) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_queue: read data phase with no expected entry, HRDATA=%h", HRDATA);
        end else begin
          exp_rd = expq.pop_front();
          check("hrdata", HRDATA, exp_rd);
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic        prev_rdy = 1'b1;
  logic [31:0] prev_wdata = '0;

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rdy, input logic dd, input logic ld);
    @(negedge HCLK);
    if (prev_rdy) HWDATA = prev_wdata;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HREADY = rdy;
    HSIZE = 3'($urandom_range(0, 7));
    dma_done_i = dd; layer_done_i = ld;
    prev_wdata = wdata;
    prev_rdy = rdy;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 2'b10, 1'b1, a, d, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [31:0] a);
    drive(1'b1, 2'b10, 1'b0, a, $urandom, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic check_rd(input logic [31:0] a, input logic [31:0] exp);
    rd(a);
    idle();
    #1 check("dir_rd", HRDATA, exp);
  endtask

  int n0;
  logic [31:0] ra, rwd;
  int rr;

  initial begin
    repeat (3) @(negedge HCLK);
    #2 HRESETn = 1'b1;
    #1 check("rst_hrdata", HRDATA, 32'd0);
    check("rst_resp", {HREADYOUT, HRESP}, 3'b100);
    for (int i = 0; i < 9; i++) check_rd(32'(i * 4), 32'd0);

    wr(32'h18, 32'hE915);
    check_rd(32'h18, 32'hE915);
    check("layer_cfg", layer_cfg, 16'hE915);
    check("cfg_fields", {layer_cfg[0], layer_cfg[2], layer_cfg[7:4], layer_cfg[12:8], layer_cfg[15:13]},
          {1'b1, 1'b1, 4'd1, 5'd9, 3'd7});

    n0 = n_lstart;
    wr(32'h1C, 1); wr(32'h1C, 1); wr(32'h1C, 0); wr(32'h1C, 1);
    repeat (4) idle();
    check("lstart_count", n_lstart - n0, 2);

    wr(32'h0C, 32'h0080_0080);
    check_rd(32'h0C, 32'd0);
    check("wh_frozen", {width, height}, 24'd0);
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle();
    check_rd(32'h20, 32'h1);
    wr(32'h0C, 32'h0080_0080);
    check_rd(32'h0C, 32'h0080_0080);
    check("wh_updated", {width, height}, {12'd128, 12'd128});

    wr(32'h04, 1);
    idle();
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    #1 check("dma_start_pulse", dma_start, 1'b1);
    idle();
    check_rd(32'h04, 32'h1);

    wr(32'h08, 32'h4000);
    rd(32'h08);
    idle();
    #1 check("b2b_bypass", HRDATA, 32'h4000);
    check_rd(32'h40, 32'd0);
    wr(32'h1000_0008, 32'h123);
    check_rd(32'h08, 32'h4000);
    check_rd(32'h24, 32'd0);

    n0 = n_lstart;
    wr(32'h1C, 0);
    idle();
    wr(32'h1C, 1);
    idle();
    #2 HRESETn = 1'b0;
    idle();
    idle();
    #2 HRESETn = 1'b1;
    repeat (3) idle();
    check("rst_no_pulse", n_lstart - n0, 0);
    check_rd(32'h20, 32'd0);
    check_rd(32'h18, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      rr = $urandom_range(0, 99);
      ra = {26'd0, 4'($urandom_range(0, 8)), 2'($urandom)};
      if (rr < 5) ra = {26'd0, 4'($urandom_range(9, 15)), 2'b00};
      else if (rr < 8) ra = $urandom | 32'h40;
      rwd = $urandom;
      drive($urandom_range(0, 9) != 0, 2'($urandom), 1'($urandom), ra, rwd,
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnn_accel_ahb_regs.md
# cnn_accel_ahb_regs

AHB-Lite slave register file fronting the CNN accelerator on the system bus. The RISC-V core writes image/layer configuration and start commands, then polls status. This block decodes those word transfers, holds the configuration, issues one-cycle start pulses to the DMA loader and layer controller, and latches their done pulses into sticky, pollable status bits.

## Interface
- W_ADDR, 32, AHB address width
- W_DATA, 32, AHB data width
- N_REGS, 9, number of mapped word registers; the register index comes from HADDR[5:2]
- HCLK  in  1  bus/accelerator clock, rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL, HWRITE  in  1  slave select, write (1) / read (0)
- HTRANS  in  2  only NONSEQ (2'b10) and SEQ (2'b11) start a transfer
- HADDR  in  W_ADDR  byte address; bits [1:0] ignored
- HSIZE  in  3  ignored; every transfer is a full 32-bit word
- HREADY  in  1  previous data phase complete
- HWDATA  in  W_DATA  write data, data phase
- HREADYOUT  out  1  always 1 (zero wait states)
- HRESP  out  2  always 2'b00 (OKAY)
- HRDATA  out  W_DATA  read data, data phase
- img_base, frame_size(25), width(12), height(12), start_up_delay(12), hsync_delay(12), base_weight(20), base_param(12), layer_cfg(16)  out  config fields
- dma_start, layer_start  out  1  single-cycle command pulses
- dma_done_i, layer_done_i  in  1  single-cycle completion pulses from the accelerator

## Operation
- Register map (offset, fields):
  - 0x00 IMG_BASE [31:0]
  - 0x04 IMG_LOAD: write bit0 = cmd; read bit0 = dma_done sticky
  - 0x08 FRAME_SIZE [24:0]
  - 0x0C WIDTH_HEIGHT: width [11:0], height [27:16]
  - 0x10 DELAY: start_up [11:0], hsync [23:12]
  - 0x14 BASE_ADDR: weight [19:0], param [31:20]
  - 0x18 LAYER_CFG [15:0]: first [0], last [1], conv3x3 [2], store_out [3], layer_index [7:4], bias_shift [12:8], act_shift [15:13]
  - 0x1C LAYER_START: write bit0 = cmd
  - 0x20 LAYER_DONE: read bit0 = done sticky, bit1 = busy
- Address phase is accepted when HSEL & HREADY & HTRANS[1]; the block registers the index and the write flag. The write takes effect at the clock edge ending the data phase, using HWDATA.
- Read data is registered at the clock edge ending the address phase, so HRDATA is valid for the whole data phase.
- Unmapped offsets (index ≥ 9, or any index with HADDR[31:6] ≠ 0): writes are ignored, reads return 0, response OKAY.
- Reads return the stored fields zero-extended. Unused bits read 0.
- Start commands:
  - Each command register stores bit0.
  - A 0→1 transition of the stored bit produces a 1-cycle pulse on the cycle after the write.
  - Writing 1 twice produces only one pulse. Software writes 0 to re-arm.
- layer_start pulse: sets busy and clears done. The dma_start pulse clears dma_done.
- layer_done_i: clears busy and sets done. dma_done_i sets dma_done.
- A done input and a clearing start pulse in the same cycle: set wins.
- While busy = 1, writes to 0x08–0x18 are ignored, so the configuration stays stable during a layer. 0x00 and 0x04 remain writable.

## Timing
- Reset (asynchronous): all registers, all outputs, done bits and busy = 0; HRDATA = 0; HREADYOUT = 1; HRESP = 0.
- Write: address phase at cycle T, data phase at T+1. The register updates at the edge ending T+1. A start pulse is high during T+2 only.
- Read: address phase at T; HRDATA is valid during T+1.
- Back-to-back pipelined transfers run at full rate.
- Write at T followed by a read of the same register at T+1: the read returns the new value. The read-data mux bypasses the pending write.
- HREADY = 0: the address phase is not sampled and the pending data phase is held.
- Reset asserted mid-transfer: the transfer is abandoned and no pulse is generated.

## Test plan
- Reset, then read every offset -> all return 0; HREADYOUT = 1, HRESP = 0.
- Write 0x18 = 0xE915, then read it -> 0xE915. Fields: first = 1, conv3x3 = 1, layer_index = 1, bias_shift = 9, act_shift = 7.
- Write 1, 1, 0, 1 to 0x1C -> exactly two layer_start pulses, each 1 cycle wide, on the cycle after the first and after the fourth write.
- During busy, write 0x0C = 0x00800080 -> WIDTH_HEIGHT is unchanged. Pulse layer_done_i -> 0x20 reads 0x1; the same write now updates width/height to 128.
- Pulse dma_done_i in the same cycle as dma_start -> 0x04 reads 1.
- Back-to-back write 0x08 = 0x4000, then read 0x08 -> HRDATA = 0x4000 in the immediately following data phase. An access to offset 0x40 -> reads 0.
